// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word-counter width; a single-word configuration still needs one bit.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/add_nbit_cin.sv
// Combinational N-bit adder slice with carry in and carry out.
module add_nbit_cin #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         c_in,
  output logic [N-1:0] sum_out,
  output logic         carry_out
);

  assign {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_in} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-word add sequencer: one N-bit slice reused over WORDS cycles, LSW first.
// Optional ADD_SEQ_SUB_EN adds sub_in for A-B mode (inverted B, carry-in of 1).
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub_in,
`endif
  input  logic [N*WORDS-1:0] a_in,
  input  logic [N*WORDS-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [N*WORDS-1:0] sum_out,
  output logic             carry_out
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Handshake: start_in is accepted only on an edge where the FSM is IDLE;
  // busy_out is high for the WORDS RUN cycles that follow, then done_out pulses
  // for exactly one cycle while sum_out/carry_out hold the finished result.
  // Requests seen in RUN or DONE are dropped, never queued.

  state_e          state, next_state;
  logic [IDX_W-1:0] idx;
  logic            carry_q;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;

  logic [N-1:0]    a_slice, b_slice, slice_sum;
  logic            slice_carry;
  int unsigned     base;
  logic            last_word;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_in) next_state = RUN;
      RUN:     if (last_word) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy_out  = (state == RUN);
  assign done_out  = (state == DONE);
  assign last_word = (idx == LAST_IDX);

  always_comb begin
    base    = 32'(idx) * 32'(N);
    a_slice = a_q[base +: N];
    b_slice = b_q[base +: N];
    if (sub_q) b_slice = ~b_slice;
  end

  add_nbit_cin #(.N(N)) u_slice (
    .a_in      (a_slice),
    .b_in      (b_slice),
    .c_in      (carry_q),
    .sum_out   (slice_sum),
    .carry_out (slice_carry)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_q <= a_in;
            b_q <= b_in;
            idx <= '0;
`ifdef ADD_SEQ_SUB_EN
            // Subtraction is A + ~B + 1, so the +1 enters as the first carry.
            sub_q   <= sub_in;
            carry_q <= sub_in;
`else
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_out[base +: N] <= slice_sum;
          carry_q            <= slice_carry;
          // Wrap to zero on the last word so idx never points past the operands.
          idx                <= last_word ? '0 : idx + 1'b1;
          if (last_word) carry_out <= slice_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed cases plus random ops, scoreboard-checked.
module tb_add_seq_ctrl;

  localparam int N     = 8;
  localparam int WORDS = 2;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];
  int done_cyc_q[$];

  add_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start),
`ifdef ADD_SEQ_SUB_EN
    .sub_in    (sub),
`endif
    .a_in      (a),
    .b_in      (b),
    .busy_out  (busy),
    .done_out  (done),
    .sum_out   (sum),
    .carry_out (cout)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: wide unsigned arithmetic, bit W is the carry / no-borrow flag
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + 1;
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (busy || done)) chk("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
    if (!rst && done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got sum=%0h carry=%0b expected no pulse", sum, cout);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {47'd0, cout, sum}, {47'd0, e});
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // driver: issue one op, check busy span and latency, return in IDLE
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit got;
    wait_idle();
    start = 1'b1; a = x; b = y; sub = s;
    @(posedge clk);
    exp_q.push_back(model(x, y, s));
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    got = 0;
    for (int i = 1; i <= WORDS + 4 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk("latency", 64'(i), 64'(WORDS + 1));
      end else begin
        chk("busy_in_run", {63'd0, busy}, 64'd1);
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt0;
    logic s;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", {63'd0, cout}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // cross-word carry and full overflow
    do_op(16'h00FF, 16'h0001, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0);

    // restart requests during RUN are ignored
    wait_idle();
    start = 1'b1; a = 16'h0013; b = 16'h0022; sub = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(16'h0013, 16'h0022, 1'b0));
    cnt0 = done_cnt;
    #1;
    a = 16'h1234; b = 16'h1111;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("single_done", 64'(done_cnt - cnt0), 64'd1);
    chk("idle_after_restart", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // back-to-back with start held high
    wait_idle();
    done_cyc_q.delete();
    start = 1'b1; a = 16'h0007; b = 16'h000A; sub = 1'b0;
    repeat (3) exp_q.push_back(model(16'h0007, 16'h000A, 1'b0));
    @(posedge clk);
    repeat (2 * (WORDS + 2)) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (WORDS + 4) @(negedge clk);
    chk("b2b_count", 64'(done_cyc_q.size()), 64'd3);
    if (done_cyc_q.size() == 3) begin
      chk("b2b_gap0", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'(WORDS + 2));
      chk("b2b_gap1", 64'(done_cyc_q[2] - done_cyc_q[1]), 64'(WORDS + 2));
    end
    @(posedge clk); #1;

    // reset during the first RUN cycle
    wait_idle();
    start = 1'b1; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk); #1;
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_carry", {63'd0, cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    do_op(16'h1234, 16'h4321, 1'b0);

`ifdef ADD_SEQ_SUB_EN
    do_op(16'h0003, 16'h0005, 1'b1);
    do_op(16'h0005, 16'h0003, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b1);
`endif

    // random ops with random idle gaps
    for (int k = 0; k < 24; k++) begin
`ifdef ADD_SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (6) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-word add sequencer. Computes one wide sum, N*WORDS bits, by time-sharing a single N-bit adder slice over WORDS clock cycles. The carry ripples through a register between words, LSW first. It sits in front of the existing N-bit adder datapath so wide operands can be added without a wide combinational carry chain.

Parameters:
N, 8, width of one adder slice in bits (>=1)
WORDS, 2, number of slices per operation (>=1); total operand width W = N*WORDS
IDX_W, $clog2(WORDS) (min 1), width of the word counter (derived localparam, not overridable)

Ports:
clk_in  input  1  rising-edge clock
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  request a new operation; sampled only in IDLE
a_in  input  W  operand A; captured when start is accepted
b_in  input  W  operand B; captured when start is accepted
busy_out  output  1  high while in RUN
done_out  output  1  one-cycle pulse; result valid
sum_out  output  W  registered wide sum
carry_out  output  1  registered carry out of the MSW

Behaviour:
- One clock domain (clk_in), one asynchronous active-high reset (rst_in); both already decided.
- Reset values: state=IDLE, idx=0, carry reg=0, operand regs=0, sum_out=0, carry_out=0, busy_out=0, done_out=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge where start_in=1:
  - latch a_in and b_in into internal registers;
  - idx<=0; carry reg<=0 (carry reg<=1 in SUB mode, see Optional Feature).
- RUN, at each edge:
  - slice k=idx: sum_out[k*N +: N] <= A[k] + B[k] + carry;
  - carry <= slice carry out; idx <= idx+1.
- RUN -> DONE at the edge that processes idx=WORDS-1; carry_out <= final slice carry at that same edge.
- DONE: done_out=1 for exactly one cycle, then IDLE unconditionally on the next edge.
- Latency: start sampled at edge t -> done_out high in the cycle after edge t+WORDS. Throughput is one op per WORDS+2 cycles with start_in held high.
- Outputs are Moore-decoded from state: busy_out=(state==RUN), done_out=(state==DONE).
- start_in in RUN or DONE is ignored, not queued. a_in/b_in changes after acceptance do not affect the result.
- sum_out and carry_out:
  - hold their value from DONE through IDLE until the next accepted start;
  - during RUN, slices update progressively and are not valid.
- Arithmetic is unsigned modulo 2^W; carry_out is bit W of the true sum.
- WORDS=1: RUN lasts one cycle; same state sequence.
- Reset asserted mid-RUN aborts immediately to reset values; no done_out pulse is produced.

Optional Feature:
Macro ADD_SEQ_SUB_EN.
- Defined: adds input port sub_in (1 bit), captured together with the operands at start.
  - sub_in=1: each B slice is bitwise inverted and the initial carry is 1, so the result is A-B mod 2^W.
  - carry_out=1 means no borrow (A>=B); carry_out=0 means borrow.
  - sub_in=0 behaves exactly as the undefined case.
- Undefined: no sub_in port; add only.

Decomposition:
- Package add_seq_pkg:
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - function for the derived IDX_W (clog2 with min 1).
- One sub-module, add_nbit_cin: the combinational N-bit slice (a_in, b_in, c_in -> sum_out, carry_out). Instantiated once.
- FSM, counter, operand registers and result registers stay in add_seq_ctrl.

Test Plan:
- Cross-word carry (N=8, WORDS=2): A=16'h00FF, B=16'h0001, start pulse -> done_out one cycle, exactly 2 edges after the start edge; sum_out=16'h0100, carry_out=0; busy_out high for 2 cycles.
- Full overflow: A=16'hFFFF, B=16'h0001 -> sum_out=16'h0000, carry_out=1.
- Ignored restart: during RUN drive start_in=1 and A=16'h1234, B=16'h1111; the original op A=16'h0013, B=16'h0022 -> sum_out=16'h0035; only one done_out pulse; the next op starts only from IDLE.
- Back-to-back: start_in held high with A=16'h0007, B=16'h000A -> done_out every 4 cycles; sum_out=16'h0011 on each pulse.
- Reset mid-op: assert rst_in during the first RUN cycle -> all outputs 0 immediately (asynchronous); no done_out; a new start after release completes normally.
- ADD_SEQ_SUB_EN defined, sub_in=1: A=16'h0003, B=16'h0005 -> sum_out=16'hFFFE, carry_out=0; A=16'h0005, B=16'h0003 -> sum_out=16'h0002, carry_out=1.
